// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full adder, one bit per clock,
// LSB first, with a start/ready/done handshake and held results.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             fa_sum;
    logic             fa_carry;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .c    (carry),
        .sum  (fa_sum),
        .carry(fa_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1: invert B at load and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout <= fa_carry;
                        ovf  <= carry ^ fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed WIDTH=16 vectors and
// protocol cases, plus an exhaustive WIDTH=4 sweep against an arithmetic model.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start16, sub16, cin16;
    logic [15:0] a16, b16, sum16;
    logic        ready16, busy16, done16, cout16, ovf16;

    logic        start4, sub4, cin4;
    logic [3:0]  a4, b4, sum4;
    logic        ready4, busy4, done4, cout4, ovf4;

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk  (clk),
        .reset(reset),
        .start(start16),
        .sub  (sub16),
        .a    (a16),
        .b    (b16),
        .cin  (cin16),
        .ready(ready16),
        .busy (busy16),
        .done (done16),
        .sum  (sum16),
        .cout (cout16),
        .ovf  (ovf16)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .reset(reset),
        .start(start4),
        .sub  (sub4),
        .a    (a4),
        .b    (b4),
        .cin  (cin4),
        .ready(ready4),
        .busy (busy4),
        .done (done4),
        .sum  (sum4),
        .cout (cout4),
        .ovf  (ovf4)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } e16_t;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       o;
    } e4_t;

    e16_t q16[$];
    e4_t  q4[$];
    e16_t m16;
    e4_t  m4;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL done16_unexpected: got done=1 expected no pending op");
            end else begin
                m16 = q16.pop_front();
                if ({sum16, cout16, ovf16} !== m16) begin
                    errors++;
                    $display("FAIL result16: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                             sum16, cout16, ovf16, m16.s, m16.c, m16.o);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL done4_unexpected: got done=1 expected no pending op");
            end else begin
                m4 = q4.pop_front();
                if ({sum4, cout4, ovf4} !== m4) begin
                    errors++;
                    $display("FAIL result4: a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                             a4, b4, sub4, sum4, cout4, ovf4, m4.s, m4.c, m4.o);
                end
            end
        end
    end

    task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb,
                            input logic tc, input logic ts,
                            input logic [15:0] es, input logic ec,
                            input logic eo, input bit push);
        int n = 0;
        while (ready16 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready16 !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready16_timeout: got ready=0 expected 1");
        end
        a16     = ta;
        b16     = tb;
        cin16   = tc;
        sub16   = ts;
        start16 = 1'b1;
        if (push) q16.push_back({es, ec, eo});
        @(posedge clk);
        #1 start16 = 1'b0;
    endtask

    task automatic wait_done16();
        int n = 0;
        while (done16 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done16 !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done16_timeout: got done=0 expected 1");
        end
    endtask

    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb,
                           input logic tc, input logic ts,
                           input logic [3:0] es, input logic ec,
                           input logic eo);
        int n = 0;
        while (ready4 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready4 !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready4_timeout: got ready=0 expected 1");
        end
        a4     = ta;
        b4     = tb;
        cin4   = tc;
        sub4   = ts;
        start4 = 1'b1;
        q4.push_back({es, ec, eo});
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        int ia, ib, sa, sb, r, cin_v;
        logic [3:0] es;
        logic ec, eo;

        reset   = 1'b1;
        start16 = 1'b0;
        sub16   = 1'b0;
        cin16   = 1'b0;
        a16     = '0;
        b16     = '0;
        start4  = 1'b0;
        sub4    = 1'b0;
        cin4    = 1'b0;
        a4      = '0;
        b4      = '0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready16), 32'd1);
        chk("reset_busy", 32'(busy16), 32'd0);
        chk("reset_done", 32'(done16), 32'd0);
        chk("reset_sum", 32'(sum16), 32'h0);
        chk("reset_cout_ovf", 32'({cout16, ovf16}), 32'd0);

        // Add with latency and hold checks.
        run_op16(16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1);
        ok = 1;
        repeat (16) begin
            @(negedge clk);
            if (busy16 !== 1'b1 || done16 !== 1'b0) ok = 0;
        end
        chk("busy_16_cycles", 32'(ok), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done16), 32'd1);
        @(negedge clk);
        chk("ready_after_done", 32'(ready16), 32'd1);
        chk("done_one_cycle", 32'(done16), 32'd0);
        chk("sum_held", 32'(sum16), 32'h2221);

        run_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        run_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        run_op16(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1);
        run_op16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
        run_op16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
        run_op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);
        run_op16(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1);

        // Operands change in the third RUN cycle.
        run_op16(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        wait_done16();

        // Start during DONE is dropped; start in the next IDLE is taken.
        a16     = 16'h5555;
        b16     = 16'h5555;
        sub16   = 1'b0;
        start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        @(negedge clk);
        chk("done_start_ignored_busy", 32'(busy16), 32'd0);
        chk("done_start_ignored_ready", 32'(ready16), 32'd1);
        run_op16(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1);
        @(negedge clk);
        chk("idle_start_accepted", 32'(busy16), 32'd1);
        wait_done16();

        // Abort in the 8th RUN cycle.
        run_op16(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready16), 32'd1);
        chk("abort_busy", 32'(busy16), 32'd0);
        chk("abort_sum", 32'(sum16), 32'h0);
        chk("abort_cout_ovf", 32'({cout16, ovf16}), 32'd0);
        ok = 1;
        repeat (24) begin
            @(negedge clk);
            if (done16 !== 1'b0) ok = 0;
        end
        chk("abort_no_done", 32'(ok), 32'd1);

        // Exhaustive WIDTH=4 sweep.
        for (int ta = 0; ta < 16; ta++) begin
            for (int tb = 0; tb < 16; tb++) begin
                for (int m = 0; m < 2; m++) begin
                    ia = ta;
                    ib = tb;
                    sa = (ia > 7) ? ia - 16 : ia;
                    sb = (ib > 7) ? ib - 16 : ib;
                    if (m == 0) begin
                        cin_v = (ia ^ (ib >> 1)) & 1;
                        r  = ia + ib + cin_v;
                        es = 4'(r % 16);
                        ec = (r >= 16);
                        r  = sa + sb + cin_v;
                    end else begin
                        cin_v = (ia >> 1) & 1;
                        es = 4'((ia - ib + 16) % 16);
                        ec = (ia >= ib);
                        r  = sa - sb;
                    end
                    eo = (r > 7) || (r < -8);
                    run_op4(4'(ta), 4'(tb), cin_v[0], m[0], es, ec, eo);
                end
            end
        end

        n = 0;
        while ((q4.size() != 0 || q16.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
